// File: rtl/toaplan2_sdram_responder_pkg.sv
//------------------------------------------------------------------------------
// Module   : toaplan2_sdram_pkg
// Brief    : Shared FSM state encoding and constants for the SDRAM responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package toaplan2_sdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_REF     = 3'd4
  } state_t;

  localparam int BANKS = 4;

  // A set mask bit means that byte is left untouched in memory.
  localparam logic       MASK_SKIP_BYTE = 1'b1;
  localparam logic [1:0] MASK_ALL_BYTES = {2{~MASK_SKIP_BYTE}};

endpackage

`default_nettype wire

// File: rtl/toaplan2_sdram_responder_if.sv
//------------------------------------------------------------------------------
// Module   : toaplan2_sdram_responder_if
// Brief    : Loader/bank-read request bus and single-port memory command bus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface toaplan2_sdram_responder_if #(
  parameter int AW = 22
);
  logic          downloading;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic [1:0]    prog_ba;
  logic          prog_rdy;
  logic [AW-1:0] ba0_addr;
  logic [AW-1:0] ba1_addr;
  logic [AW-1:0] ba2_addr;
  logic [AW-1:0] ba3_addr;
  logic [3:0]    ba_rd;
  logic [3:0]    ba_ack;
  logic [3:0]    ba_dst;
  logic [3:0]    ba_dok;
  logic [3:0]    ba_rdy;
  logic [15:0]   data_read;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_ba;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_mask;
  logic          mem_ref;
  logic          mem_gnt;
  logic          mem_dvalid;
  logic [15:0]   mem_dout;

  modport slave (
    input  downloading, prog_we, prog_addr, prog_data, prog_mask, prog_ba,
    input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
    input  mem_gnt, mem_dvalid, mem_dout,
    output prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
    output mem_req, mem_we, mem_ba, mem_addr, mem_din, mem_mask, mem_ref
  );

  modport master (
    output downloading, prog_we, prog_addr, prog_data, prog_mask, prog_ba,
    output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
    output mem_gnt, mem_dvalid, mem_dout,
    input  prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
    input  mem_req, mem_we, mem_ba, mem_addr, mem_din, mem_mask, mem_ref
  );
endinterface

`default_nettype wire

// File: rtl/toaplan2_sdram_responder_arb.sv
//------------------------------------------------------------------------------
// Module   : toaplan2_rr_arb4
// Brief    : 4-way round-robin arbiter; search starts at i_ptr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module toaplan2_rr_arb4
  import toaplan2_sdram_pkg::*;
(
  input  logic [BANKS-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic [BANKS-1:0] o_grant,
  output logic [1:0]       o_grant_idx,
  output logic             o_any
);

  logic [1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = i_ptr;
    o_any       = 1'b0;
    w_idx       = i_ptr;
    for (int i = BANKS - 1; i >= 0; i--) begin
      w_idx = i_ptr + 2'(i);
      if (i_req[w_idx]) begin
        o_grant     = BANKS'(1) << w_idx;
        o_grant_idx = w_idx;
        o_any       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/toaplan2_sdram_responder.sv
//------------------------------------------------------------------------------
// Module   : toaplan2_sdram_responder
// Brief    : Serialises loader writes and 4 bank reads onto one memory port.
//            Optional refresh slots with macro TOAPLAN2_SDRAM_REFRESH_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module toaplan2_sdram_responder
  import toaplan2_sdram_pkg::*;
#(
  parameter int AW    = 22,
  parameter int BURST = 2
`ifdef TOAPLAN2_SDRAM_REFRESH_EN
  ,
  parameter int REF_INT = 384
`endif
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  toaplan2_sdram_responder_if.slave bus
);

  localparam logic [1:0] c_LAST_BEAT = 2'(BURST - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_bank;
  logic [BANKS-1:0] r_bank_oh;
  logic [1:0]       r_beat;
  logic             r_we_guard;
  logic [BANKS-1:0] r_ack_hold;

  logic             r_prog_rdy;
  logic [BANKS-1:0] r_ba_ack;
  logic [BANKS-1:0] r_ba_dst;
  logic [BANKS-1:0] r_ba_dok;
  logic [BANKS-1:0] r_ba_rdy;
  logic [15:0]      r_data_read;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [1:0]       r_mem_ba;
  logic [AW-1:0]    r_mem_addr;
  logic [15:0]      r_mem_din;
  logic [1:0]       r_mem_mask;

  logic [BANKS-1:0] w_rd_req;
  logic [BANKS-1:0] w_grant;
  logic [1:0]       w_grant_idx;
  logic             w_rd_any;
  logic             w_wr_req;
  logic             w_take_wr;
  logic [AW-1:0]    w_rd_addr;

  // A bank is masked during its ACK cycle and the one after, covering a late drop.
  assign w_rd_req  = bus.ba_rd & ~(r_ba_ack | r_ack_hold);
  assign w_wr_req  = bus.prog_we & ~r_we_guard;
  assign w_take_wr = w_wr_req & (bus.downloading | ~w_rd_any);

  toaplan2_rr_arb4 u_arb (
    .i_req       (w_rd_req),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_rd_any)
  );

  always_comb begin
    w_rd_addr = bus.ba0_addr;
    case (w_grant_idx)
      2'd0:    w_rd_addr = bus.ba0_addr;
      2'd1:    w_rd_addr = bus.ba1_addr;
      2'd2:    w_rd_addr = bus.ba2_addr;
      default: w_rd_addr = bus.ba3_addr;
    endcase
  end

`ifdef TOAPLAN2_SDRAM_REFRESH_EN
  localparam logic [8:0] c_REF_LAST = 9'(REF_INT - 1);

  logic [8:0] r_ref_cnt;
  logic       r_ref_due;
  logic       r_mem_ref;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ref_cnt <= '0;
      r_ref_due <= 1'b0;
    end else if (r_state == ST_REF && bus.mem_gnt) begin
      r_ref_cnt <= '0;
      r_ref_due <= 1'b0;
    end else if (r_ref_cnt == c_REF_LAST) begin
      r_ref_due <= 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 9'd1;
    end
  end

  assign bus.mem_ref = r_mem_ref;
`else
  assign bus.mem_ref = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_bank      <= '0;
      r_bank_oh   <= '0;
      r_beat      <= '0;
      r_we_guard  <= 1'b0;
      r_ack_hold  <= '0;
      r_prog_rdy  <= 1'b0;
      r_ba_ack    <= '0;
      r_ba_dst    <= '0;
      r_ba_dok    <= '0;
      r_ba_rdy    <= '0;
      r_data_read <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_ba    <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_mask  <= '0;
`ifdef TOAPLAN2_SDRAM_REFRESH_EN
      r_mem_ref   <= 1'b0;
`endif
    end else begin
      r_prog_rdy <= 1'b0;
      r_ba_ack   <= '0;
      r_ba_dst   <= '0;
      r_ba_dok   <= '0;
      r_ba_rdy   <= '0;
      r_ack_hold <= r_ba_ack;
      if (!bus.prog_we) r_we_guard <= 1'b0;

      case (r_state)
        ST_IDLE: begin
`ifdef TOAPLAN2_SDRAM_REFRESH_EN
          if (r_ref_due) begin
            r_mem_ref <= 1'b1;
            r_state   <= ST_REF;
          end else
`endif
          if (w_take_wr) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_ba   <= bus.prog_ba;
            r_mem_addr <= bus.prog_addr;
            r_mem_din  <= bus.prog_data;
            r_mem_mask <= bus.prog_mask;
            r_state    <= ST_WR;
          end else if (w_rd_any) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_ba   <= w_grant_idx;
            r_mem_addr <= w_rd_addr;
            r_mem_din  <= '0;
            r_mem_mask <= MASK_ALL_BYTES;
            r_bank     <= w_grant_idx;
            r_bank_oh  <= w_grant;
            r_ptr      <= w_grant_idx + 2'd1;
            r_state    <= ST_RD_CMD;
          end
        end
        ST_WR: begin
          if (bus.mem_gnt) begin
            r_mem_req  <= 1'b0;
            r_prog_rdy <= 1'b1;
            r_we_guard <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_RD_CMD: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_ba_ack  <= r_bank_oh;
            r_beat    <= '0;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (bus.mem_dvalid) begin
            r_data_read <= bus.mem_dout;
            r_ba_dok    <= r_bank_oh;
            if (r_beat == 2'd0) r_ba_dst <= r_bank_oh;
            if (r_beat == c_LAST_BEAT) begin
              r_ba_rdy <= r_bank_oh;
              r_state  <= ST_IDLE;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end
        end
`ifdef TOAPLAN2_SDRAM_REFRESH_EN
        ST_REF: begin
          if (bus.mem_gnt) begin
            r_mem_ref <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.prog_rdy  = r_prog_rdy;
  assign bus.ba_ack    = r_ba_ack;
  assign bus.ba_dst    = r_ba_dst;
  assign bus.ba_dok    = r_ba_dok;
  assign bus.ba_rdy    = r_ba_rdy;
  assign bus.data_read = r_data_read;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_ba    = r_mem_ba;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;
  assign bus.mem_mask  = r_mem_mask;

endmodule

`default_nettype wire

// File: tb/tb_toaplan2_sdram_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_toaplan2_sdram_responder
// Brief    : Scoreboard bench: directed stimulus, queued expectations, monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_toaplan2_sdram_responder;

  localparam int AW    = 22;
  localparam int BURST = 2;

  typedef struct packed {
    logic          we;
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [1:0]    mask;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  dok;
    logic [3:0]  dst;
    logic [3:0]  rdy;
    logic [15:0] data;
  } dat_t;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  toaplan2_sdram_responder_if #(.AW(AW)) bus ();

  toaplan2_sdram_responder #(.AW(AW), .BURST(BURST)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  cmd_t        cmd_q[$];
  dat_t        dat_q[$];
  logic [3:0]  ack_q[$];
  logic [15:0] rd_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          rdy_seen    = 0;
  int          gnt_delay   = 0;
  logic        hold_we     = 1'b0;
  logic [3:0]  ack_prev    = '0;
  cmd_t        mon_exp, mon_act;
  dat_t        mon_dexp, mon_dact;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, required nothing", name, act);
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.prog_rdy, bus.ba_ack, bus.ba_dst, bus.ba_dok, bus.ba_rdy, bus.data_read,
            bus.mem_req, bus.mem_we, bus.mem_ba, bus.mem_addr, bus.mem_din, bus.mem_mask,
            bus.mem_ref};
  endfunction

  // Memory model: grants after gnt_delay cycles, then streams BURST words.
  initial begin
    int words_left = 0;
    int waited     = 0;
    bus.mem_gnt    = 1'b0;
    bus.mem_dvalid = 1'b0;
    bus.mem_dout   = '0;
    forever begin
      @(posedge CLK);
      #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_dvalid = 1'b0;
      if (!RESET_N) begin
        words_left = 0;
        waited     = 0;
      end else if (words_left > 0) begin
        bus.mem_dvalid = 1'b1;
        bus.mem_dout   = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
        words_left--;
      end else if (bus.mem_req) begin
        if (waited >= gnt_delay) begin
          bus.mem_gnt = 1'b1;
          waited      = 0;
          if (!bus.mem_we) words_left = BURST;
        end else begin
          waited++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (bus.mem_req && bus.mem_gnt) begin
        if (cmd_q.size() == 0) unexpected("mem_cmd", {bus.mem_we, bus.mem_ba, bus.mem_addr});
        else begin
          mon_exp = cmd_q.pop_front();
          mon_act = {bus.mem_we, bus.mem_ba, bus.mem_addr, bus.mem_din, bus.mem_mask};
          if (!mon_exp.we) begin
            mon_exp.din = '0; mon_exp.mask = '0;
            mon_act.din = '0; mon_act.mask = '0;
          end
          check("mem_cmd", mon_act, mon_exp);
        end
      end
      if (|bus.ba_ack) begin
        if (ack_q.size() == 0) unexpected("ba_ack", bus.ba_ack);
        else check("ba_ack", bus.ba_ack, ack_q.pop_front());
      end
      if (|bus.ba_dok) begin
        mon_dact = {bus.ba_dok, bus.ba_dst, bus.ba_rdy, bus.data_read};
        if (dat_q.size() == 0) unexpected("read_word", mon_dact);
        else begin
          mon_dexp = dat_q.pop_front();
          check("read_word", mon_dact, mon_dexp);
        end
      end else if (|(bus.ba_dst | bus.ba_rdy)) begin
        unexpected("strobe_without_dok", {bus.ba_dst, bus.ba_rdy});
      end
      if (bus.prog_rdy) rdy_seen++;
    end
  end

  // Requester side: drop BA_RD one cycle after ACK, PROG_WE on PROG_RDY unless held.
  task automatic tick();
    @(posedge CLK);
    #1;
    bus.ba_rd = bus.ba_rd & ~ack_prev;
    ack_prev  = bus.ba_ack;
    if (!hold_we && bus.prog_rdy) bus.prog_we = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((cmd_q.size() + dat_q.size() + ack_q.size()) != 0 && n < 300) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({name, "_drain"}, cmd_q.size() + dat_q.size() + ack_q.size(), 0);
  endtask

  task automatic expect_read(input logic [1:0] b, input logic [AW-1:0] a,
                             input logic [15:0] w0, input logic [15:0] w1);
    logic [3:0] oh;
    oh = 4'b0001 << b;
    cmd_q.push_back({1'b0, b, a, 16'h0000, 2'b00});
    ack_q.push_back(oh);
    rd_q.push_back(w0);
    rd_q.push_back(w1);
    dat_q.push_back({oh, oh, 4'b0000, w0});
    dat_q.push_back({oh, 4'b0000, oh, w1});
  endtask

  initial begin
    int n;
    bus.downloading = 1'b0;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
    bus.prog_mask   = '0;
    bus.prog_ba     = '0;
    bus.ba0_addr    = '0;
    bus.ba1_addr    = '0;
    bus.ba2_addr    = '0;
    bus.ba3_addr    = '0;
    bus.ba_rd       = '0;
    #2 RESET_N = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), '0);
    RESET_N = 1'b1;
    tick();

    // Loader write, granted late, inputs changed while the command waits
    rdy_seen = 0; gnt_delay = 3; bus.downloading = 1'b1;
    cmd_q.push_back({1'b1, 2'd1, 22'h012345, 16'hA5A5, 2'b10});
    bus.prog_addr = 22'h012345; bus.prog_data = 16'hA5A5;
    bus.prog_mask = 2'b10;      bus.prog_ba   = 2'd1;
    bus.prog_we   = 1'b1;
    tick(); tick();
    bus.prog_addr = 22'h3FFFFF; bus.prog_data = 16'h0000;
    drain("write");
    check("write_prog_rdy_count", rdy_seen, 1);

    // Held write request must not commit twice
    rdy_seen = 0; gnt_delay = 1; hold_we = 1'b1;
    cmd_q.push_back({1'b1, 2'd2, 22'h000ABC, 16'h1234, 2'b00});
    bus.prog_addr = 22'h000ABC; bus.prog_data = 16'h1234;
    bus.prog_mask = 2'b00;      bus.prog_ba   = 2'd2;
    bus.prog_we   = 1'b1;
    n = 0;
    while (rdy_seen == 0 && n < 60) begin tick(); n++; end
    check("held_first_rdy", rdy_seen, 1);
    repeat (5) tick();
    check("held_no_recommit", rdy_seen, 1);
    bus.prog_we = 1'b0;
    tick();
    cmd_q.push_back({1'b1, 2'd2, 22'h000ABD, 16'h5678, 2'b01});
    bus.prog_addr = 22'h000ABD; bus.prog_data = 16'h5678; bus.prog_mask = 2'b01;
    bus.prog_we = 1'b1; hold_we = 1'b0;
    drain("held_rewrite");
    check("held_total_rdy", rdy_seen, 2);

    // Round-robin with all four banks requesting, immediate grant/data
    bus.downloading = 1'b0; gnt_delay = 0;
    bus.ba0_addr = 22'h000100; bus.ba1_addr = 22'h000101;
    bus.ba2_addr = 22'h000102; bus.ba3_addr = 22'h000103;
    for (int b = 0; b < 4; b++)
      expect_read(2'(b), 22'h000100 + 22'(b), 16'h0A00 + 16'(2 * b), 16'h0A01 + 16'(2 * b));
    bus.ba_rd = 4'b1111;
    drain("round_robin");

    // Single burst on bank 1 at the top half of the address space
    gnt_delay = 2;
    bus.ba1_addr = 22'h200000;
    expect_read(2'd1, 22'h200000, 16'h1111, 16'h2222);
    bus.ba_rd[1] = 1'b1;
    drain("burst_bank1");

    // Write beats read while downloading
    rdy_seen = 0; gnt_delay = 1; bus.downloading = 1'b1;
    bus.ba0_addr = 22'h000055;
    cmd_q.push_back({1'b1, 2'd3, 22'h000777, 16'hCAFE, 2'b00});
    expect_read(2'd0, 22'h000055, 16'h3333, 16'h4444);
    bus.prog_addr = 22'h000777; bus.prog_data = 16'hCAFE;
    bus.prog_mask = 2'b00;      bus.prog_ba   = 2'd3;
    bus.prog_we = 1'b1; bus.ba_rd[0] = 1'b1;
    drain("prio_download");
    check("prio_download_rdy", rdy_seen, 1);

    // Read beats write when not downloading
    rdy_seen = 0; bus.downloading = 1'b0;
    bus.ba0_addr = 22'h000066;
    expect_read(2'd0, 22'h000066, 16'h5555, 16'h6666);
    cmd_q.push_back({1'b1, 2'd0, 22'h000888, 16'hBEAD, 2'b11});
    bus.prog_addr = 22'h000888; bus.prog_data = 16'hBEAD;
    bus.prog_mask = 2'b11;      bus.prog_ba   = 2'd0;
    bus.prog_we = 1'b1; bus.ba_rd[0] = 1'b1;
    drain("prio_normal");
    check("prio_normal_rdy", rdy_seen, 1);

    // Reset in the middle of a burst, then a fresh burst on the same bank
    gnt_delay = 0;
    bus.ba2_addr = 22'h03F0F0;
    expect_read(2'd2, 22'h03F0F0, 16'hBEEF, 16'hDEAD);
    bus.ba_rd[2] = 1'b1;
    n = 0;
    while (!bus.ba_dok[2] && n < 50) begin tick(); n++; end
    check("midburst_first_word_seen", bus.ba_dok, 4'b0100);
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    check("midburst_reset_outputs", all_outs(), '0);
    cmd_q.delete(); dat_q.delete(); ack_q.delete(); rd_q.delete();
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    bus.ba2_addr = 22'h001234;
    expect_read(2'd2, 22'h001234, 16'hC0DE, 16'hF00D);
    bus.ba_rd[2] = 1'b1;
    drain("post_reset_burst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
